// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared memory-port widths, vectors and arbiter encodings
package mem_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    localparam logic [7:0] RESET_VEC = 8'h00;
    localparam logic [7:0] IRQ_VEC   = 8'h01;

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } arb_state_t;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_IF   = 2'd1,
        SEL_DM   = 2'd2
    } arb_sel_t;

endpackage

// File: rtl/mem_arb_prio.sv
// rtl/mem_arb_prio.sv - data-first priority select with forced fetch on starvation
module mem_arb_prio
    import mem_pkg::*;
(
    input  logic     en,
    input  logic     if_req,
    input  logic     dm_req,
    input  logic     if_force,
    output arb_sel_t sel
);

    always_comb begin
        sel = SEL_NONE;
        if (en) begin
            // Data wins unless fetch has been starved for the full streak.
            if (dm_req && !(if_req && if_force)) begin
                sel = SEL_DM;
            end else if (if_req) begin
                sel = SEL_IF;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter for fetch and data, with boot vector read
module mem_port_arbiter #(
    parameter int                ADDR_W     = mem_pkg::ADDR_W,
    parameter int                DATA_W     = mem_pkg::DATA_W,
    parameter logic [ADDR_W-1:0] RESET_VEC  = ADDR_W'(mem_pkg::RESET_VEC),
    parameter int                MAX_STREAK = 3,
    parameter int                STREAK_W   = 2
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,

    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,

    output logic [DATA_W-1:0] rdata,
    output logic              boot_valid,
    output logic [ADDR_W-1:0] boot_pc,

    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    import mem_pkg::*;

    arb_state_t          state_q;
    arb_state_t          state_d;
    logic [STREAK_W-1:0] streak_q;
    arb_sel_t            sel;
    logic                run;
    logic                starve;

    assign run    = (state_q == ST_RUN) && !reset;
    assign starve = (streak_q == STREAK_W'(MAX_STREAK));

    mem_arb_prio u_prio (
        .en       (run),
        .if_req   (if_req),
        .dm_req   (dm_req),
        .if_force (starve),
        .sel      (sel)
    );

    // Reset gates every memory strobe and grant combinationally so an
    // access cut short by reset never reaches the memory.
    always_comb begin
        state_d   = state_q;
        if_gnt    = 1'b0;
        dm_gnt    = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (!reset) begin
            case (state_q)
                ST_BOOT: begin
                    mem_read = 1'b1;
                    mem_addr = RESET_VEC;
                    state_d  = ST_RUN;
                end
                ST_RUN: begin
                    case (sel)
                        SEL_IF: begin
                            if_gnt   = 1'b1;
                            mem_read = 1'b1;
                            mem_addr = if_addr;
                        end
                        SEL_DM: begin
                            dm_gnt   = 1'b1;
                            mem_addr = dm_addr;
                            if (dm_we) begin
                                mem_write = 1'b1;
                                mem_wdata = dm_wdata;
                            end else begin
                                mem_read = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
                default: state_d = ST_BOOT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_BOOT;
            streak_q   <= '0;
            rdata      <= '0;
            boot_pc    <= '0;
            boot_valid <= 1'b0;
            if_rvalid  <= 1'b0;
            dm_rvalid  <= 1'b0;
        end else begin
            state_q   <= state_d;
            if_rvalid <= if_gnt;
            dm_rvalid <= dm_gnt;
            if (state_q == ST_BOOT) begin
                boot_pc    <= ADDR_W'(mem_rdata);
                boot_valid <= 1'b1;
            end
            if (mem_read && (state_q == ST_RUN)) begin
                rdata <= mem_rdata;
            end
            // Streak counts data wins only while fetch is actually waiting.
            if (if_gnt || !if_req) begin
                streak_q <= '0;
            end else if (dm_gnt && !starve) begin
                streak_q <= streak_q + 1'b1;
            end
        end
    end

    a_one_grant : assert property (@(posedge clk) disable iff (reset) !(if_gnt && dm_gnt));
    a_boot_quiet : assert property (@(posedge clk) disable iff (reset)
        (state_q == ST_BOOT) |-> !(if_gnt || dm_gnt || mem_write));

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sits between the pipeline and the single 256-byte Von Neumann memory.
- Shares the one memory port between the instruction-fetch requester (IF) and the data-memory requester (MEM stage).
- After reset, performs the boot read of the reset vector and hands the start PC to the fetch unit.
- Data accesses normally win; a bounded-streak counter prevents fetch starvation.

Parameters:
- ADDR_W, 8, memory address width
- DATA_W, 8, memory data width
- RESET_VEC, 8'h00, address holding the start PC
- MAX_STREAK, 3, consecutive data grants allowed while fetch is pending before fetch is forced
- STREAK_W, 2, width of the streak counter (must hold MAX_STREAK)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request; held until if_gnt
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  fetch granted this cycle (combinational)
- if_rvalid  out  1  fetch read data valid (one cycle after grant)
- dm_req  in  1  data request; held until dm_gnt
- dm_we  in  1  1 = write, 0 = read
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  write data
- dm_gnt  out  1  data granted this cycle (combinational)
- dm_rvalid  out  1  data read valid / write done (one cycle after grant)
- rdata  out  DATA_W  registered read data shared by both requesters
- boot_valid  out  1  level; boot_pc is valid
- boot_pc  out  ADDR_W  contents of mem[RESET_VEC]
- mem_read  out  1  to memory read enable
- mem_write  out  1  to memory write enable
- mem_addr  out  ADDR_W  to memory address
- mem_wdata  out  DATA_W  to memory data_in
- mem_rdata  in  DATA_W  from memory data_out (asynchronous read)

Behaviour:
- Reset is asynchronous, active-high.
  - On reset: state=BOOT, streak=0, rdata=0, boot_pc=0, boot_valid=0, if_rvalid=0, dm_rvalid=0.
  - While reset is high, mem_read, mem_write, if_gnt and dm_gnt are forced to 0.
- FSM has two states: BOOT and RUN.
- BOOT (exactly 1 cycle after reset deasserts):
  - Drive mem_read=1, mem_addr=RESET_VEC; no grants issued.
  - At the clock edge: boot_pc<=mem_rdata, boot_valid<=1, state<=RUN.
  - boot_valid stays high until the next reset.
- RUN, grant rule (combinational, one access per cycle):
  - Only dm_req: dm_gnt.
  - Only if_req: if_gnt.
  - Both requesting: dm_gnt unless streak==MAX_STREAK, in which case if_gnt.
  - Neither requesting: no grant; mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
  - if_gnt and dm_gnt are never high together.
- Memory drive:
  - Fetch grant: mem_read=1, mem_addr=if_addr.
  - Data read grant: mem_read=1, mem_addr=dm_addr.
  - Data write grant: mem_write=1, mem_read=0, mem_addr=dm_addr, mem_wdata=dm_wdata.
- Response timing, at the clock edge ending a grant cycle:
  - On a read grant: rdata<=mem_rdata.
  - The matching rvalid is high for exactly the following cycle.
  - Writes: dm_rvalid pulses as a completion ack; rdata holds its previous value.
  - rdata holds its value between reads.
- Latency: grant in cycle N, data on rdata with rvalid in cycle N+1. Back-to-back grants give one access per cycle.
- Streak counter:
  - Increments when dm_gnt && if_req.
  - Clears when if_gnt or !if_req.
  - Saturates at MAX_STREAK.
- A requester must keep req/addr/we/wdata stable until it sees its gnt. The arbiter does not latch requests.
- Reset asserted mid-access: any in-flight rvalid is dropped, and the write in the current cycle is suppressed (mem_write forced 0).
- Address wrap: none needed; full 8-bit space, addresses 0..255 passed through unchanged.

Decomposition:
- Shared package (mem_pkg): ADDR_W/DATA_W, RESET_VEC=8'h00, IRQ_VEC=8'h01, arbiter state encoding (BOOT, RUN).
- No sub-module required. Grant logic and the streak counter stay inline; optionally split out as mem_arb_prio (pure combinational priority select) if reuse is wanted.

Test Plan:
1. mem[0]=8'h10, release reset -> mem_read=1, mem_addr=0 for one cycle; next cycle boot_valid=1, boot_pc=8'h10; no grants during BOOT.
2. if_req=1, if_addr=8'h10, mem[16]=8'hC0 -> if_gnt same cycle; next cycle if_rvalid=1, rdata=8'hC0.
3. dm_req=1, dm_we=1, dm_addr=8'h40, dm_wdata=8'h5A, then data read of 8'h40 -> mem_write one cycle, dm_rvalid ack; read returns rdata=8'h5A.
4. if_req and dm_req both held continuously (reads), MAX_STREAK=3 -> grant sequence dm,dm,dm,if,dm,dm,dm,if; the two gnts are never simultaneous.
5. Data read, then reset asserted mid-cycle during a data write to 8'h41 -> mem_write drops immediately, mem[0x41] unchanged, all rvalid=0, FSM re-enters BOOT and re-reads mem[0].
6. No requests for 5 cycles in RUN -> mem_read=0, mem_write=0, rdata keeps its last value, streak stays 0.
